// File: rtl/chacha_inv_rounds_pkg.sv
// chacha_inv_rounds_pkg: shared widths, rotate amounts, quarterround index tables and FSM encoding
package chacha_inv_rounds_pkg;
    localparam int WORD_W  = 32;
    localparam int STATE_W = 512;
    localparam int NWORDS  = 16;
    localparam int ROT_A   = 16;
    localparam int ROT_B   = 12;
    localparam int ROT_C   = 8;
    localparam int ROT_D   = 7;
    localparam logic [3:0] COL_IDX [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };
    localparam logic [3:0] DIAG_IDX [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };
    typedef enum logic [1:0] {ST_IDLE, ST_ROUNDS, ST_DONE} fsm_t;
    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction
endpackage

// File: rtl/chacha_qr_inv.sv
// chacha_qr_inv: combinational inverse ChaCha quarterround, forward steps undone in reverse order
module chacha_qr_inv
    import chacha_inv_rounds_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] c,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] a_prim,
    output logic [WORD_W-1:0] b_prim,
    output logic [WORD_W-1:0] c_prim,
    output logic [WORD_W-1:0] d_prim
);
    logic [WORD_W-1:0] w_b1, w_c1, w_d1, w_a1, w_b2, w_c2, w_d2;
    assign w_b1   = rotr(b, ROT_D) ^ c;
    assign w_c1   = c - d;
    assign w_d1   = rotr(d, ROT_C) ^ a;
    assign w_a1   = a - w_b1;
    assign w_b2   = rotr(w_b1, ROT_B) ^ w_c1;
    assign w_c2   = w_c1 - w_d1;
    assign w_d2   = rotr(w_d1, ROT_A) ^ w_a1;
    assign a_prim = w_a1 - w_b2;
    assign b_prim = w_b2;
    assign c_prim = w_c2;
    assign d_prim = w_d2;
endmodule

// File: rtl/chacha_inv_rounds.sv
// chacha_inv_rounds: iterative ChaCha round inverter, one column or diagonal round undone per clock
module chacha_inv_rounds
    import chacha_inv_rounds_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [4:0]         rounds,
    input  logic [STATE_W-1:0] data_in,
    output logic               ready,
    output logic [STATE_W-1:0] data_out,
    output logic               data_out_valid
);
    fsm_t               r_fsm, w_fsm_next;
    logic [STATE_W-1:0] r_state, w_next_state;
    logic [4:0]         r_ctr;
    logic               r_valid, w_accept, w_diag;
    logic [WORD_W-1:0]  w_word [NWORDS];
    logic [WORD_W-1:0]  w_nw [NWORDS];
    logic [WORD_W-1:0]  w_qi [4][4];
    logic [WORD_W-1:0]  w_qo [4][4];

    // k = ctr-1 is odd (diagonal round) exactly when ctr is even
    assign w_diag = ~r_ctr[0];

    genvar i, g, j;
    generate
        for (i = 0; i < NWORDS; i++) begin : g_unpack
            assign w_word[i] = r_state[STATE_W-1-WORD_W*i -: WORD_W];
        end
        for (g = 0; g < 4; g++) begin : g_qr
            for (j = 0; j < 4; j++) begin : g_sel
                assign w_qi[g][j] = w_diag ? w_word[DIAG_IDX[g][j]] : w_word[COL_IDX[g][j]];
            end
            chacha_qr_inv u_qr (
                .a      (w_qi[g][0]),
                .b      (w_qi[g][1]),
                .c      (w_qi[g][2]),
                .d      (w_qi[g][3]),
                .a_prim (w_qo[g][0]),
                .b_prim (w_qo[g][1]),
                .c_prim (w_qo[g][2]),
                .d_prim (w_qo[g][3])
            );
        end
    endgenerate

    always_comb begin
        w_nw = w_word;
        for (int q = 0; q < 4; q++)
            for (int k = 0; k < 4; k++)
                w_nw[w_diag ? DIAG_IDX[q][k] : COL_IDX[q][k]] = w_qo[q][k];
        w_next_state = '0;
        for (int n = 0; n < NWORDS; n++)
            w_next_state[STATE_W-1-WORD_W*n -: WORD_W] = w_nw[n];
    end

    assign ready          = (r_fsm != ST_ROUNDS);
    assign data_out       = r_state;
    assign data_out_valid = r_valid;

    always_comb begin
        w_accept   = start && ready;
        w_fsm_next = r_fsm;
        if (w_accept)
            w_fsm_next = (rounds != 5'd0) ? ST_ROUNDS : ST_DONE;
        else if (r_fsm == ST_ROUNDS && r_ctr == 5'd1)
            w_fsm_next = ST_DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_ctr   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_fsm <= w_fsm_next;
            if (w_accept) begin
                r_state <= data_in;
                r_ctr   <= rounds;
                r_valid <= (rounds == 5'd0);
            end else if (r_fsm == ST_ROUNDS) begin
                r_state <= w_next_state;
                r_ctr   <= r_ctr - 5'd1;
                r_valid <= (r_ctr == 5'd1);
            end
        end
    end
endmodule

// File: doc/chacha_inv_rounds.md
Name: chacha_inv_rounds

Overview:
- Iterative inverse of the ChaCha round function. It takes a 512-bit state that has been through N column/diagonal rounds, with no final feed-forward addition, and undoes the rounds one per cycle to recover the original 16-word state.
- It sits alongside the forward core. Uses: model-free self-check of the forward datapath, known-answer recovery in the test harness, and fault-detection hooks.
- Four parallel inverse quarterrounds are applied per clock.

Parameters:
- none. Round count is a run-time input and is latched per job.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse that requests a new job. Accepted only while ready=1.
- rounds  in  5  number of forward rounds to undo, 0..31. Sampled with start.
- data_in  in  512  state to invert. Sampled with start.
- ready  out  1  block can accept start.
- data_out  out  512  recovered state.
- data_out_valid  out  1  data_out holds a completed result.

Behaviour:
- Word mapping: word i occupies bits [511-32*i -: 32], on both data_in and data_out.
- Reset (async, active-high):
  - state = IDLE, ready = 1, data_out_valid = 0.
  - data_out = 0, round counter = 0.
- FSM states: IDLE, ROUNDS, DONE.
- IDLE/DONE with start=1, at edge E0:
  - Latch data_in into the state register and rounds into ctr.
  - data_out_valid -> 0.
  - Next state is ROUNDS if rounds != 0, otherwise DONE with data_out_valid = 1 and data_out = data_in unchanged.
- ROUNDS, each edge:
  - Round index k = ctr-1.
  - k even: undo a column round. Inverse QR on word tuples (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
  - k odd: undo a diagonal round. Inverse QR on (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - ctr decrements.
  - When ctr == 1 before the edge: next state DONE, data_out_valid = 1.
- Latency: data_out_valid is first high after edge E0+N, where N = latched rounds. This holds for N=0 too.
- ready = 1 in IDLE and DONE, 0 in ROUNDS.
- start while ready = 0 is ignored with no side effects. data_in and rounds may change freely after E0.
- DONE holds data_out and data_out_valid stable until the next accepted start. That start clears valid on the same edge it loads the new job.
- Odd N is legal; index ordering handles it, ending on an inverse column round. N = 8, 12 and 20 are the production cases.
- Reset asserted mid-job aborts immediately to the reset values. No partial result is exposed.
- Inverse QR arithmetic: all values 32-bit, modulo 2^32; rotr = rotate right. Inputs a,b,c,d are the forward outputs, and steps run in this order:
  1. b = rotr(b,7) ^ c
  2. c = c - d
  3. d = rotr(d,8) ^ a
  4. a = a - b
  5. b = rotr(b,12) ^ c
  6. c = c - d
  7. d = rotr(d,16) ^ a
  8. a = a - b
- Each step uses the values produced by the previous steps.
- The inverse QR is purely combinational. There is one register stage: the 512-bit state.

Decomposition:
- Shared package:
  - Word width 32.
  - State width 512.
  - Rotate constants 16/12/8/7.
  - Column and diagonal index tables.
  - FSM state encoding.
- Sub-module chacha_qr_inv: combinational, ports a,b,c,d in / a_prim,b_prim,c_prim,d_prim out. It mirrors the forward QR port shape and is instantiated four times, with the input mux selecting column or diagonal tuples by k[0].

Test Plan:
- chacha_qr_inv standalone: a=ea2a92f4, b=cb1cf8ce, c=4581472e, d=5881c4bb -> a=11111111, b=01020304, c=9b8d6f43, d=01234567 (RFC 7539 2.1.1 inverted).
- Round trip, rounds=20: take the RFC 7539 2.3.2 initial state through the forward core without feed-forward. Feed that result -> data_out equals the initial state, and valid rises after exactly 20 edges past E0.
- rounds=0: data_in = 0x0123...cdef pattern -> valid after E0 with data_out == data_in. rounds=1 -> only the column inverse is applied, checked against the golden model.
- Handshake: start pulsed during ROUNDS with different data -> ignored, result unchanged. Back-to-back start in DONE -> valid drops for one job and a new result appears after N edges.
- Reset mid-job: assert reset at ctr=7 of a rounds=12 job -> outputs immediately read ready=1, valid=0, data_out=0. A following job completes correctly.
- Random: 1000 random states with rounds drawn from {8,12,20} and odd values -> forward-then-inverse is the identity in every case.
